// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-port request/ack arbiter owning a shared memory with registered mirrors
module mem_port_arbiter #(
    parameter int AW         = 5,
    parameter int DW         = 8,
    parameter int A_PRIORITY = 0,
    parameter int MIR0_ADDR  = 3,
    parameter int MIR1_ADDR  = 4,
    parameter int MIR2_ADDR  = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          busy,
    output logic [DW-1:0] mir0,
    output logic [DW-1:0] mir1,
    output logic [DW-1:0] mir2
);
    typedef enum logic [1:0] {IDLE, GRANT, ACCESS, DONE} state_t;
    localparam logic [AW-1:0] M0 = AW'(MIR0_ADDR);
    localparam logic [AW-1:0] M1 = AW'(MIR1_ADDR);
    localparam logic [AW-1:0] M2 = AW'(MIR2_ADDR);
    state_t        state, state_nx;
    logic [DW-1:0] mem [2**AW];
    logic          own_b, last_b, we_q, pick_b;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rd_val;

    // Winner in IDLE: lone requester, else fixed A priority or the port that did not go last
    always_comb begin
        pick_b = b_req & (~a_req | ((A_PRIORITY == 0) & ~last_b));
        rd_val = we_q ? wdata_q : mem[addr_q];
    end

    // Next state: a transaction walks GRANT, ACCESS, DONE and returns to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (a_req | b_req) ? GRANT : IDLE;
            GRANT:   state_nx = ACCESS;
            ACCESS:  state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clock) state <= reset ? IDLE : state_nx;

    // Capture the winner's request at grant and record the owner of each finished transaction
    always_ff @(posedge clock) begin
        if (reset) begin
            last_b <= 1'b1;
        end else begin
            if (state == IDLE && (a_req | b_req)) begin
                own_b   <= pick_b;
                we_q    <= pick_b ? b_we : a_we;
                addr_q  <= pick_b ? b_addr : a_addr;
                wdata_q <= pick_b ? b_wdata : a_wdata;
            end
            if (state == DONE) last_b <= own_b;
        end
    end

    // Write commits at the end of ACCESS unless reset arrives in the same cycle
    always_ff @(posedge clock) if (!reset && state == ACCESS && we_q) mem[addr_q] <= wdata_q;

    // Registered acks, read data, busy and mirrors
    always_ff @(posedge clock) begin
        if (reset) begin
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_rdata <= '0;
            b_rdata <= '0;
            busy    <= 1'b0;
            mir0    <= '0;
            mir1    <= '0;
            mir2    <= '0;
        end else begin
            a_ack <= state == ACCESS & ~own_b;
            b_ack <= state == ACCESS & own_b;
            if (state == ACCESS & ~own_b) a_rdata <= rd_val;
            if (state == ACCESS & own_b) b_rdata <= rd_val;
            busy <= state_nx == GRANT || state_nx == ACCESS;
            mir0 <= mem[M0];
            mir1 <= mem[M1];
            mir2 <= mem[M2];
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level model check of round-robin and A-priority arbiters
module tb_mem_port_arbiter;
    logic       clock = 1'b0, reset = 1'b1;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [4:0] a_addr = '0, b_addr = '0;
    logic [7:0] a_wdata = '0, b_wdata = '0;
    logic [1:0] aack, back, busy;
    logic [7:0] ard [2], brd [2], mir [2][3];
    int         errors = 0, checks = 0;

    always #5 clock = ~clock;

    // instance 0 round-robin, instance 1 A-priority, same stimulus
    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_port_arbiter #(.A_PRIORITY(g)) u_dut (
            .clock(clock), .reset(reset),
            .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
            .a_ack(aack[g]), .a_rdata(ard[g]),
            .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
            .b_ack(back[g]), .b_rdata(brd[g]),
            .busy(busy[g]), .mir0(mir[g][0]), .mir1(mir[g][1]), .mir2(mir[g][2])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // transaction-level model: one transaction in flight, identified by its age in cycles since grant
    bit         act [2], own [2], mwe [2], last_b [2];
    int         age [2];
    logic [4:0] mad [2];
    logic [7:0] mwd [2];
    logic [7:0] mem [2][32];
    bit         known [2][32];
    bit         e_aack [2], e_back [2], e_busy [2], e_ard_ok [2], e_brd_ok [2], e_mir_ok [2][3];
    logic [7:0] e_ard [2], e_brd [2], e_mir [2][3];
    int         maddr [3] = '{3, 4, 7};
    logic [7:0] rv;
    bit         rok;

    always @(posedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                act[k] = 0; last_b[k] = 1;
                e_aack[k] = 0; e_back[k] = 0; e_busy[k] = 0;
                e_ard[k] = 0; e_brd[k] = 0; e_ard_ok[k] = 1; e_brd_ok[k] = 1;
                for (int j = 0; j < 3; j++) begin e_mir[k][j] = 0; e_mir_ok[k][j] = 1; end
            end else begin
                for (int j = 0; j < 3; j++) begin
                    e_mir[k][j] = mem[k][maddr[j]];
                    e_mir_ok[k][j] = known[k][maddr[j]];
                end
                e_aack[k] = 0; e_back[k] = 0; e_ard_ok[k] = 0; e_brd_ok[k] = 0;
                if (act[k]) begin
                    age[k]++;
                    if (age[k] == 2) begin
                        rv = mwe[k] ? mwd[k] : mem[k][mad[k]];
                        rok = mwe[k] || known[k][mad[k]];
                        if (mwe[k]) begin mem[k][mad[k]] = mwd[k]; known[k][mad[k]] = 1; end
                        if (own[k]) begin e_back[k] = 1; e_brd[k] = rv; e_brd_ok[k] = rok; end
                        else begin e_aack[k] = 1; e_ard[k] = rv; e_ard_ok[k] = rok; end
                    end else if (age[k] == 3) begin
                        act[k] = 0; last_b[k] = own[k];
                    end
                end else if (a_req || b_req) begin
                    own[k] = b_req && (!a_req || (k == 0 && !last_b[k]));
                    mwe[k] = own[k] ? b_we : a_we;
                    mad[k] = own[k] ? b_addr : a_addr;
                    mwd[k] = own[k] ? b_wdata : a_wdata;
                    act[k] = 1; age[k] = 0;
                end
                e_busy[k] = act[k] && age[k] < 2;
            end
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("a_ack[%0d]", k), 32'(aack[k]), 32'(e_aack[k]));
            chk($sformatf("b_ack[%0d]", k), 32'(back[k]), 32'(e_back[k]));
            chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(e_busy[k]));
            if (e_ard_ok[k]) chk($sformatf("a_rdata[%0d]", k), 32'(ard[k]), 32'(e_ard[k]));
            if (e_brd_ok[k]) chk($sformatf("b_rdata[%0d]", k), 32'(brd[k]), 32'(e_brd[k]));
            for (int j = 0; j < 3; j++)
                if (e_mir_ok[k][j]) chk($sformatf("mir%0d[%0d]", j, k), 32'(mir[k][j]), 32'(e_mir[k][j]));
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    // one request on a port, held until its ack on instance 0; glitch drops/alters port A after grant
    task automatic xact(input bit pb, input bit we, input logic [4:0] ad, input logic [7:0] wd,
                        input bit glitch, output logic [7:0] rd, output int lat);
        lat = 0;
        rd = 'x;
        if (pb) begin b_req = 1; b_we = we; b_addr = ad; b_wdata = wd; end
        else begin a_req = 1; a_we = we; a_addr = ad; a_wdata = wd; end
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            step();
            if (glitch && n == 1) begin a_req = 0; a_addr = ~ad; a_wdata = ~wd; end
            if (pb ? back[0] : aack[0]) begin
                lat = n;
                rd = pb ? brd[0] : ard[0];
                if (pb) b_req = 0; else a_req = 0;
            end
        end
        if (lat == 0) chk("xact_timeout", 0, 1);
        step();
    endtask

    initial begin
        logic [7:0]  rd;
        int          lat;
        logic [19:0] ra [2], rb [2];
        repeat (3) step();
        reset = 0;
        // B write then A read of the same word
        xact(1, 1, 5'd1, 8'h0D, 0, rd, lat);
        chk("t1_b_lat", lat, 3);
        xact(0, 0, 5'd1, 8'h00, 0, rd, lat);
        chk("t1_a_lat", lat, 3);
        chk("t1_a_rdata", 32'(rd), 32'h0D);
        xact(1, 1, 5'd4, 8'h44, 0, rd, lat);
        xact(1, 1, 5'd7, 8'h77, 0, rd, lat);
        xact(0, 1, 5'd5, 8'h55, 0, rd, lat);
        // mirror of addr 3 two cycles after ACCESS, others unchanged
        xact(0, 1, 5'd3, 8'h1B, 0, rd, lat);
        chk("t4_lat", lat, 3);
        chk("t4_wr_rdata", 32'(rd), 32'h1B);
        chk("t4_mir0", 32'(mir[0][0]), 32'h1B);
        chk("t4_mir1", 32'(mir[0][1]), 32'h44);
        chk("t4_mir2", 32'(mir[0][2]), 32'h77);
        // request dropped and address changed after grant
        xact(0, 0, 5'd1, 8'h00, 1, rd, lat);
        chk("t6_lat", lat, 3);
        chk("t6_rdata", 32'(rd), 32'h0D);
        // reset during ACCESS aborts the write
        b_req = 1; b_we = 1; b_addr = 5'd5; b_wdata = 8'hFF;
        step(); step();
        chk("t5_busy_access", 32'(busy[0]), 1);
        reset = 1; b_req = 0;
        step();
        reset = 0;
        chk("t5_no_ack", 32'(back[0]), 0);
        chk("t5_busy", 32'(busy[0]), 0);
        step();
        chk("t5_no_ack_late", 32'(back[0]), 0);
        xact(0, 0, 5'd5, 8'h00, 0, rd, lat);
        chk("t5_mem_kept", 32'(rd), 32'h55);
        // ties after reset: round-robin alternates, A-priority starves B until a_req drops
        reset = 1;
        step();
        reset = 0;
        a_req = 1; a_we = 0; a_addr = 5'd1; b_req = 1; b_we = 0; b_addr = 5'd7;
        for (int k = 0; k < 2; k++) begin ra[k] = '0; rb[k] = '0; end
        for (int n = 1; n <= 16; n++) begin
            step();
            for (int k = 0; k < 2; k++) begin ra[k][n] = aack[k]; rb[k][n] = back[k]; end
            if (n == 11) a_req = 0;
            if (n == 15) b_req = 0;
        end
        chk("t2_rr_a_acks", 32'(ra[0]), 32'h00808);
        chk("t2_rr_b_acks", 32'(rb[0]), 32'h08080);
        chk("t3_pri_a_acks", 32'(ra[1]), 32'h00888);
        chk("t3_pri_b_acks", 32'(rb[1]), 32'h08000);
        step();
        // random traffic with occasional resets and mid-transaction input changes
        for (int c = 0; c < 3000; c++) begin
            step();
            reset = ($urandom_range(0, 149) == 0);
            if (!a_req || e_aack[0]) begin
                a_req = e_aack[0] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
                a_we = 1'($urandom_range(0, 1)); a_addr = 5'($urandom); a_wdata = 8'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                a_addr = 5'($urandom); a_wdata = 8'($urandom); a_req = 1'($urandom_range(0, 1));
            end
            if (!b_req || e_back[0]) begin
                b_req = e_back[0] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
                b_we = 1'($urandom_range(0, 1)); b_addr = 5'($urandom); b_wdata = 8'($urandom);
            end else if ($urandom_range(0, 7) == 0) begin
                b_addr = 5'($urandom); b_wdata = 8'($urandom); b_req = 1'($urandom_range(0, 1));
            end
        end
        reset = 0; a_req = 0; b_req = 0;
        repeat (6) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
